virtual_ds2431_byte_io: RTL and testbench
=========================================

// Module: virtual_ds2431_byte_io
// PURPOSE
// 1-Wire slave byte transceiver; sits below the DS2431 command handlers (e.g. Read Memory).
// Serves master time slots on the DQ line: writes one byte LSB-first (drives 0-bits low),
// or reads one byte by sampling. Also detects master reset pulses and answers with a presence pulse.
// Handshake with handlers: sentDat/nRxTx/transTrig in, rxDat/ByteTransDone out.
// PARAMETERS
// SAMPLE_DLY  120   cycles from slot fall detect to RX sample (15us @ 8MHz)
// TX_HOLD     240   cycles dqOe held for a TX 0-bit; also minimum slot length (30us)
// RST_MIN     3840  consecutive low cycles that qualify a bus reset (480us)
// PRES_WAIT   240   cycles from reset release to presence start (30us)
// PRES_LEN    960   presence pulse length in cycles (120us)
// PORTS
// clk            in   1  system clock
// nRst           in   1  synchronous active-low reset
// dqIn           in   1  raw DQ line level (asynchronous)
// dqOe           out  1  1 = pull DQ low (open-drain enable)
// sentDat        in   8  byte to transmit, latched on transTrig
// nRxTx          in   1  1 = transmit sentDat, 0 = receive, latched on transTrig
// transTrig      in   1  one-cycle start pulse; honoured only when busy=0
// rxDat          out  8  last received byte, valid from ByteTransDone onward
// ByteTransDone  out  1  one-cycle pulse: byte completed (TX or RX)
// busReset       out  1  one-cycle pulse when low time reaches RST_MIN
// busy           out  1  1 from transTrig accept until byte done/abort
// BEHAVIOUR
// - Reset (nRst=0 at clk edge): dqOe=0, rxDat=8'h00, ByteTransDone=0, busReset=0, busy=0; state IDLE.
// - dqIn passes a 2-FF synchronizer -> dqS; fall = dqS_prev & ~dqS. Latency 2 cycles, counted in all delays.
// - States: IDLE, ARMED, SLOT, RST_LOW, PRES_WAIT, PRES.
// - IDLE: transTrig -> latch sentDat into shift reg, latch nRxTx, bitCnt=0, busy=1, ARMED.
//   A fall in IDLE is ignored (DQ floats; master reads 1).
// - ARMED: on fall -> slotCnt=0, SLOT. transTrig ignored while busy.
// - SLOT: slotCnt increments each cycle (saturating, 13-bit).
//   TX: if shift[0]=0, dqOe=1 for slotCnt 0..TX_HOLD-1, then 0. 1-bits never drive.
//   RX: at slotCnt==SAMPLE_DLY, shift in dqS at MSB (shift right). Bytes are LSB-first.
//   Bit end: slotCnt>=TX_HOLD and dqS=1 -> bitCnt+1, shift TX reg right.
//     bitCnt<7 -> ARMED. bitCnt==7 -> rxDat<=shift (RX only), ByteTransDone=1 for 1 cycle, busy=0, IDLE.
// - Low counter lowCnt: counts consecutive dqS=0 cycles in every state except PRES; clears when dqS=1.
//   lowCnt==RST_MIN-1 -> busReset pulse, dqOe=0, busy=0, RST_LOW. Priority over everything.
//   A byte in progress is aborted: no ByteTransDone, rxDat unchanged.
// - RST_LOW: wait dqS=1 -> PRES_WAIT. After PRES_WAIT cycles -> PRES.
//   In PRES: dqOe=1 for PRES_LEN cycles -> IDLE. transTrig ignored in RST_LOW/PRES_WAIT/PRES.
// - Same-cycle transTrig and reset qualification: reset wins, trigger dropped.
// - Own dqOe low must not count toward lowCnt in PRES.
//   A TX 0-bit (<TX_HOLD) can never reach RST_MIN.
// - Sync nRst mid-byte or mid-presence: immediate return to reset values; dqOe released next edge.
// TESTING
// - TX 8'hA5: 8 master slots 60us -> dqOe low ~30us in slots 1,3,4,6 (0-bits); ByteTransDone pulse after slot 8.
// - RX: nRxTx=0, master writes 8'h3C (0-bits low 60us, 1-bits low 6us) -> rxDat=8'h3C, one ByteTransDone.
// - Reset mid-byte: 3 slots, then DQ low 500us -> busReset pulse, no ByteTransDone.
//   Presence dqOe=1 for 960 cycles starting 240 cycles after release.
// - transTrig while busy (sentDat=8'h00) ignored; original byte 8'hFF completes, no dqOe pulses.
// - Slot falls in IDLE -> dqOe stays 0, no ByteTransDone. Then nRst=0 during PRES -> dqOe=0 next cycle, state IDLE.

Source files
------------

// File: rtl/virtual_ds2431_byte_io.sv
// virtual_ds2431_byte_io: 1-Wire slave byte transceiver with bus-reset detection and presence reply.
// Ports: clk, nRst (sync, active low), dqIn (raw DQ), dqOe (1 = pull DQ low),
//        sentDat/nRxTx/transTrig (byte request), rxDat/ByteTransDone (byte result),
//        busReset (reset pulse seen), busy (byte in progress).
module virtual_ds2431_byte_io #(
    parameter int unsigned SAMPLE_DLY = 120,
    parameter int unsigned TX_HOLD    = 240,
    parameter int unsigned RST_MIN    = 3840,
    parameter int unsigned PRES_WAIT  = 240,
    parameter int unsigned PRES_LEN   = 960
) (
    input  logic       clk,
    input  logic       nRst,
    input  logic       dqIn,
    output logic       dqOe,
    input  logic [7:0] sentDat,
    input  logic       nRxTx,
    input  logic       transTrig,
    output logic [7:0] rxDat,
    output logic       ByteTransDone,
    output logic       busReset,
    output logic       busy
);
    typedef enum logic [2:0] {IDLE, ARMED, SLOT, RST_LOW, PRESWAIT, PRES} stateT;

    localparam logic [12:0] sampleAt     = 13'(SAMPLE_DLY);
    localparam logic [12:0] txHold       = 13'(TX_HOLD);
    localparam logic [12:0] txHoldLast   = 13'(TX_HOLD - 1);
    localparam logic [12:0] rstLast      = 13'(RST_MIN - 1);
    localparam logic [12:0] presWaitLast = 13'(PRES_WAIT - 1);
    localparam logic [12:0] presLenLast  = 13'(PRES_LEN - 1);
    localparam logic [12:0] cntMax       = '1;

    stateT       state;
    logic        dqMeta, dqS, dqPrev, isTx;
    logic [7:0]  shiftReg;
    logic [2:0]  bitCnt;
    logic [12:0] slotCnt, lowCnt;
    logic        fall;

    assign fall = dqPrev & ~dqS;

    always_ff @(posedge clk) begin
        if (!nRst) begin
            state         <= IDLE;
            dqMeta        <= 1'b1;
            dqS           <= 1'b1;
            dqPrev        <= 1'b1;
            isTx          <= 1'b0;
            shiftReg      <= '0;
            bitCnt        <= '0;
            slotCnt       <= '0;
            lowCnt        <= '0;
            dqOe          <= 1'b0;
            rxDat         <= '0;
            ByteTransDone <= 1'b0;
            busReset      <= 1'b0;
            busy          <= 1'b0;
        end else begin
            dqMeta        <= dqIn;
            dqS           <= dqMeta;
            dqPrev        <= dqS;
            ByteTransDone <= 1'b0;
            busReset      <= 1'b0;
            // Our own presence pulse holds DQ low, so it must not look like a master reset.
            lowCnt        <= (dqS || state == PRES) ? '0 : lowCnt + 13'(lowCnt != cntMax);
            if (state != PRES && !dqS && lowCnt == rstLast) begin
                busReset <= 1'b1;
                dqOe     <= 1'b0;
                busy     <= 1'b0;
                state    <= RST_LOW;
            end else begin
                case (state)
                    IDLE: if (transTrig) begin
                        shiftReg <= sentDat;
                        isTx     <= nRxTx;
                        bitCnt   <= '0;
                        busy     <= 1'b1;
                        state    <= ARMED;
                    end
                    ARMED: if (fall) begin
                        slotCnt <= '0;
                        dqOe    <= isTx & ~shiftReg[0];
                        state   <= SLOT;
                    end
                    SLOT: begin
                        slotCnt <= slotCnt + 13'(slotCnt != cntMax);
                        if (slotCnt == txHoldLast) dqOe <= 1'b0;
                        if (!isTx && slotCnt == sampleAt) shiftReg <= {dqS, shiftReg[7:1]};
                        // The slot ends once the minimum length has passed and the line is back high.
                        if (slotCnt >= txHold && dqS) begin
                            bitCnt <= bitCnt + 3'd1;
                            if (isTx) shiftReg <= {1'b0, shiftReg[7:1]};
                            if (bitCnt == 3'd7) begin
                                if (!isTx) rxDat <= shiftReg;
                                ByteTransDone <= 1'b1;
                                busy          <= 1'b0;
                                state         <= IDLE;
                            end else begin
                                state <= ARMED;
                            end
                        end
                    end
                    RST_LOW: if (dqS) begin
                        slotCnt <= '0;
                        state   <= PRESWAIT;
                    end
                    PRESWAIT: begin
                        slotCnt <= slotCnt + 13'd1;
                        if (slotCnt == presWaitLast) begin
                            slotCnt <= '0;
                            dqOe    <= 1'b1;
                            state   <= PRES;
                        end
                    end
                    PRES: begin
                        slotCnt <= slotCnt + 13'd1;
                        if (slotCnt == presLenLast) begin
                            dqOe  <= 1'b0;
                            state <= IDLE;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_virtual_ds2431_byte_io.sv
// tb_virtual_ds2431_byte_io: scoreboard bench for the 1-Wire slave byte transceiver.
`timescale 1ns/1ps
module tb_virtual_ds2431_byte_io;
    logic       clk = 1'b0;
    logic       nRst = 1'b0;
    logic       masterLow = 1'b0;
    logic       dqIn;
    logic       dqOe;
    logic [7:0] sentDat = 8'h00;
    logic       nRxTx = 1'b0;
    logic       transTrig = 1'b0;
    logic [7:0] rxDat;
    logic       ByteTransDone, busReset, busy;

    int checks = 0;
    int errors = 0;
    int doneCnt = 0;
    int rstCnt = 0;
    int oeCnt = 0;
    logic [8:0] expQ[$];

    // Open-drain bus: either side pulling low wins.
    assign dqIn = ~(masterLow | dqOe);

    always #5 clk = ~clk;

    virtual_ds2431_byte_io dut (
        .clk(clk), .nRst(nRst), .dqIn(dqIn), .dqOe(dqOe), .sentDat(sentDat), .nRxTx(nRxTx),
        .transTrig(transTrig), .rxDat(rxDat), .ByteTransDone(ByteTransDone),
        .busReset(busReset), .busy(busy)
    );

    task automatic tick();
        @(negedge clk);
        if (ByteTransDone) doneCnt++;
        if (busReset) rstCnt++;
        if (dqOe) oeCnt++;
    endtask

    task automatic masterSlot(input int lowCyc, input int totalCyc);
        for (int i = 0; i < totalCyc; i++) begin
            masterLow = (i < lowCyc);
            tick();
        end
        masterLow = 1'b0;
    endtask

    task automatic startByte(input logic tx, input logic [7:0] data);
        sentDat = data;
        nRxTx = tx;
        transTrig = 1'b1;
        tick();
        transTrig = 1'b0;
        expQ.push_back({tx, data});
    endtask

    task automatic checkByte(input string name, input int d0);
        logic [8:0] e;
        checks++;
        if (doneCnt !== d0 + 1) begin
            errors++;
            $display("FAIL %s done count: got %0d expected %0d", name, doneCnt - d0, 1);
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL %s busy after done: got %b expected 0", name, busy);
        end
        checks++;
        if (expQ.size() == 0) begin
            errors++;
            $display("FAIL %s scoreboard empty: got 0 entries expected 1", name);
        end else begin
            e = expQ.pop_front();
            if (!e[8] && rxDat !== e[7:0]) begin
                errors++;
                $display("FAIL %s rxDat: got %h expected %h", name, rxDat, e[7:0]);
            end
        end
    endtask

    task automatic txSlots(input string name, input logic [7:0] data, input int first);
        for (int i = first; i < 8; i++) begin
            oeCnt = 0;
            masterSlot(8, 480);
            checks++;
            if (oeCnt !== (data[i] ? 0 : 240)) begin
                errors++;
                $display("FAIL %s slot %0d dqOe cycles: got %0d expected %0d", name, i, oeCnt,
                         data[i] ? 0 : 240);
            end
        end
    endtask

    task automatic rxSlots(input logic [7:0] data);
        for (int i = 0; i < 8; i++) masterSlot(data[i] ? 48 : 480, 500);
    endtask

    task automatic busResetPulse(input string name);
        int r0;
        r0 = rstCnt;
        masterSlot(4000, 4000);
        checks++;
        if (rstCnt !== r0 + 1) begin
            errors++;
            $display("FAIL %s busReset pulses: got %0d expected 1", name, rstCnt - r0);
        end
    endtask

    task automatic test_reset();
        nRst = 1'b0;
        repeat (3) tick();
        checks += 5;
        if (dqOe !== 1'b0) begin errors++; $display("FAIL reset dqOe: got %b expected 0", dqOe); end
        if (rxDat !== 8'h00) begin errors++; $display("FAIL reset rxDat: got %h expected 00", rxDat); end
        if (ByteTransDone !== 1'b0) begin errors++; $display("FAIL reset done: got %b expected 0", ByteTransDone); end
        if (busReset !== 1'b0) begin errors++; $display("FAIL reset busReset: got %b expected 0", busReset); end
        if (busy !== 1'b0) begin errors++; $display("FAIL reset busy: got %b expected 0", busy); end
        nRst = 1'b1;
        repeat (5) tick();
    endtask

    task automatic test_tx();
        int d0;
        d0 = doneCnt;
        startByte(1'b1, 8'hA5);
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL tx busy: got %b expected 1", busy); end
        txSlots("tx_a5", 8'hA5, 0);
        checkByte("tx_a5", d0);
    endtask

    task automatic test_rx();
        int d0;
        d0 = doneCnt;
        oeCnt = 0;
        startByte(1'b0, 8'h3C);
        rxSlots(8'h3C);
        checkByte("rx_3c", d0);
        checks++;
        if (oeCnt !== 0) begin errors++; $display("FAIL rx dqOe cycles: got %0d expected 0", oeCnt); end
    endtask

    task automatic test_busy_trig();
        int d0;
        d0 = doneCnt;
        oeCnt = 0;
        startByte(1'b1, 8'hFF);
        masterSlot(8, 480);
        sentDat = 8'h00;
        nRxTx = 1'b1;
        transTrig = 1'b1;
        tick();
        transTrig = 1'b0;
        for (int i = 1; i < 8; i++) masterSlot(8, 480);
        checks++;
        if (oeCnt !== 0) begin errors++; $display("FAIL busy_trig dqOe cycles: got %0d expected 0", oeCnt); end
        checkByte("busy_trig", d0);
    endtask

    task automatic test_reset_mid_byte();
        int d0, r0, n, len;
        d0 = doneCnt;
        startByte(1'b0, 8'h99);
        for (int i = 0; i < 3; i++) masterSlot(48, 500);
        busResetPulse("mid_byte");
        r0 = rstCnt;
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL mid_byte busy: got %b expected 0", busy); end
        n = 0;
        while (!dqOe && n < 400) begin tick(); n++; end
        checks++;
        if (n < 240 || n > 245) begin
            errors++;
            $display("FAIL presence delay: got %0d expected 240..245", n);
        end
        len = 0;
        for (int i = 0; i < 2000; i++) begin
            if (!dqOe) break;
            len++;
            tick();
        end
        checks += 4;
        if (len !== 960) begin errors++; $display("FAIL presence length: got %0d expected 960", len); end
        if (doneCnt !== d0) begin errors++; $display("FAIL mid_byte done: got %0d expected 0", doneCnt - d0); end
        if (rstCnt !== r0) begin errors++; $display("FAIL presence busReset: got %0d expected 0", rstCnt - r0); end
        if (rxDat !== 8'h3C) begin errors++; $display("FAIL mid_byte rxDat: got %h expected 3c", rxDat); end
        expQ.delete();
        repeat (10) tick();
    endtask

    task automatic test_idle_falls();
        int d0, n;
        d0 = doneCnt;
        oeCnt = 0;
        for (int i = 0; i < 3; i++) masterSlot(8, 480);
        checks += 2;
        if (oeCnt !== 0) begin errors++; $display("FAIL idle dqOe cycles: got %0d expected 0", oeCnt); end
        if (doneCnt !== d0) begin errors++; $display("FAIL idle done: got %0d expected 0", doneCnt - d0); end
        busResetPulse("idle_rst");
        n = 0;
        while (!dqOe && n < 400) begin tick(); n++; end
        checks++;
        if (!dqOe) begin errors++; $display("FAIL pres start: got dqOe %b expected 1", dqOe); end
        repeat (100) tick();
        nRst = 1'b0;
        tick();
        checks += 3;
        if (dqOe !== 1'b0) begin errors++; $display("FAIL nRst in pres dqOe: got %b expected 0", dqOe); end
        if (busy !== 1'b0) begin errors++; $display("FAIL nRst in pres busy: got %b expected 0", busy); end
        if (rxDat !== 8'h00) begin errors++; $display("FAIL nRst in pres rxDat: got %h expected 00", rxDat); end
        nRst = 1'b1;
        repeat (5) tick();
    endtask

    task automatic test_back_to_back();
        int d0;
        d0 = doneCnt;
        startByte(1'b0, 8'hC3);
        rxSlots(8'hC3);
        checkByte("b2b_rx", d0);
        d0 = doneCnt;
        startByte(1'b1, 8'h5A);
        txSlots("b2b_tx", 8'h5A, 0);
        checkByte("b2b_tx", d0);
        checks++;
        if (rxDat !== 8'hC3) begin errors++; $display("FAIL b2b rxDat kept: got %h expected c3", rxDat); end
    endtask

    initial begin
        test_reset();
        test_tx();
        test_rx();
        test_busy_trig();
        test_reset_mid_byte();
        test_idle_falls();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end
endmodule
